axis_packet_framer: RTL and testbench
=====================================

Name: axis_packet_framer

Overview:
- Downstream stage of the AXI-stream fan-in; consumes its merged stream (data, tlast, binary channel number on tuser).
- Prepends one header beat per packet carrying a magic word, the source channel and a per-channel sequence number.
- Enforces a maximum payload length by truncating and discarding the overflow.
- Output is fully registered through a skid buffer, so both m_axis_* and s_axis_tready are register-driven.

Parameters:
- NUM_CHAN, 6, number of upstream channels; tuser width; 1..256.
- DATA_WIDTH, 256, beat width; must be >= 64.
- SEQ_WIDTH, 16, per-channel sequence counter width.
- MAX_WORDS, 1024, maximum payload beats per packet, excluding the header; >= 2.
- HDR_MAGIC, 16'hA55A, header magic constant.

Ports:
- s_axis_clk  in  1  single clock for the whole block.
- s_axis_rstn  in  1  reset, asynchronous, active-low.
- s_axis_tvalid  in  1  upstream valid.
- s_axis_tready  out  1  upstream ready.
- s_axis_tdata  in  DATA_WIDTH  payload.
- s_axis_tlast  in  1  end of packet.
- s_axis_tuser  in  NUM_CHAN  binary source channel number.
- m_axis_tvalid  out  1  downstream valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tdata  out  DATA_WIDTH  header or payload beat.
- m_axis_tlast  out  1  end of framed packet.
- m_axis_tuser  out  2  bit0 = header beat, bit1 = truncated-packet last beat.
- err_chan  out  1  one-cycle pulse: tuser >= NUM_CHAN at packet start.
- trunc_count  out  16  saturating count of truncated packets.

Behaviour:
- Reset (async assert, sync release): state IDLE, all seq counters 0, trunc_count 0, err_chan 0, skid buffer empty, m_axis_tvalid 0, s_axis_tready 0, m_axis_tdata/tlast/tuser 0.
- Core-to-skid handshake: core drives c_valid/c_data/c_last/c_user; a beat transfers when c_valid and c_ready.
- Skid buffer: 2 entries. c_ready = registered "not full". Output is registered; one-cycle latency from core transfer to m_axis.
- Header layout:
  - [15:0] HDR_MAGIC
  - [15+SEQ_WIDTH:16] seq
  - [SEQ_WIDTH+23:SEQ_WIDTH+16] channel, zero-extended to 8 bits
  - all higher bits 0.
- State IDLE:
  - s_axis_tready=0.
  - When s_axis_tvalid: c_valid=1, c_data=header for chan=s_axis_tuser, c_user=01, c_last=0.
  - On transfer: latch chan; increment seq[chan] (wraps 2^SEQ_WIDTH-1 -> 0); word count <= 0; go PAYLOAD.
  - Header therefore appears on m_axis one cycle after the first s_axis_tvalid, given an empty skid.
- Out-of-range tuser (>= NUM_CHAN): header seq field all ones, no counter update, err_chan pulses the cycle the header transfers, packet otherwise passed.
- State PAYLOAD:
  - Pass-through: s_axis_tready=c_ready, c_valid=s_axis_tvalid, c_data=s_axis_tdata, c_user=00.
  - s_axis_tuser ignored mid-packet.
  - Each accepted beat increments word count.
  - Accepted beat with tlast: c_last=1; go IDLE.
  - Accepted beat with count==MAX_WORDS-1 and tlast=0: forward with c_last=1, c_user=10; trunc_count++ (saturate at 16'hFFFF); go DRAIN.
  - Beat with count==MAX_WORDS-1 and tlast=1: normal end, no truncation.
- State DRAIN:
  - s_axis_tready=1, c_valid=0; discard beats.
  - Accepted beat with tlast: go IDLE.
- Back-to-back packets: the next packet's header may transfer in the cycle after the previous tlast transfer; no bubble is required beyond that.
- Zero-payload packets do not exist: every upstream packet has at least one beat, so output length = input beats + 1.
- Reset mid-packet: all state dropped. Upstream remainder after reset release is framed as a new packet with a fresh header.
- m_axis_tdata/tlast/tuser hold stable while m_axis_tvalid && !m_axis_tready (AXI-stream rule, checked in verification).

Decomposition:
- Package axis_framer_pkg holds: header field offsets and widths (magic, seq, chan), HDR_MAGIC default, state encoding (IDLE, PAYLOAD, DRAIN), tuser bit indices (HDR_BIT=0, TRUNC_BIT=1).
- Sub-module axis_skid_buffer: 2-entry registered slice parameterized by width. Reusable elsewhere, instantiated once here over {user, last, data}.
- Seq counter array and FSM stay in the top module.

Test Plan:
- Single 3-beat packet on chan 2, m_axis_tready=1 -> 4 beats out. Header = {seq 0, chan 2, magic A55A} with tuser=01; beats 2-4 match input; last beat tlast=1; header appears 1 cycle after first tvalid.
- Three packets chan 1, 1, 4 -> headers carry seq 0, 1, 0; seq[1]=2. With SEQ_WIDTH=2, a 5th chan-1 packet carries seq 0 (wrap).
- MAX_WORDS=4, 7-beat packet -> header + 4 payload beats, 4th with tlast=1 and tuser=10; 3 beats discarded; trunc_count=1. A following packet is framed normally.
- Random m_axis_tready (50%) over 100 random packets -> scoreboard exact match; no beat loss or duplication; data held stable while stalled.
- tuser=7 with NUM_CHAN=6 -> err_chan one pulse; header seq all ones; no counter changes.
- s_axis_rstn asserted mid-payload -> m_axis_tvalid 0 immediately (async); counters 0. Next beat after release gets a header with seq 0.

Source files
------------

// File: rtl/axis_framer_pkg.sv
// Shared constants for the AXI-stream packet framer: header field placement,
// FSM state encoding and output tuser bit meanings.
package axis_framer_pkg;

    // Header field placement. The channel field sits directly above the
    // sequence field, so its LSB depends on the sequence width.
    localparam int MAGIC_LSB = 0;
    localparam int MAGIC_W   = 16;
    localparam int SEQ_LSB   = 16;
    localparam int CHAN_W    = 8;

    localparam logic [15:0] HDR_MAGIC_DEFAULT = 16'hA55A;

    // Framer FSM encoding
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PAYLOAD = 2'd1;
    localparam logic [1:0] ST_DRAIN   = 2'd2;

    // Output tuser bits
    localparam int USER_W    = 2;
    localparam int HDR_BIT   = 0;
    localparam int TRUNC_BIT = 1;

    // LSB of the channel field for a given sequence counter width
    function automatic int chan_lsb(input int seq_width);
        return SEQ_LSB + seq_width;
    endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry registered pipeline slice. Both the output side and the input
// ready come straight from flops; a second (skid) entry absorbs the beat that
// arrives while the output is stalled, so full throughput is kept.
module axis_skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data
);

    logic             ready_reg, ready_next;
    logic             out_valid_reg, out_valid_next;
    logic             skid_valid_reg, skid_valid_next;
    logic [WIDTH-1:0] out_data_reg, out_data_next;
    logic [WIDTH-1:0] skid_data_reg, skid_data_next;
    logic             in_fire;
    logic             out_free;

    assign in_fire  = s_valid && ready_reg;
    assign out_free = !out_valid_reg || m_ready;

    // Next-state: refill the output entry from skid first, then from input
    always_comb begin
        out_valid_next  = out_valid_reg;
        out_data_next   = out_data_reg;
        skid_valid_next = skid_valid_reg;
        skid_data_next  = skid_data_reg;
        if (out_free) begin
            if (skid_valid_reg) begin
                out_valid_next  = 1'b1;
                out_data_next   = skid_data_reg;
                skid_valid_next = in_fire;
                skid_data_next  = in_fire ? s_data : skid_data_reg;
            end else begin
                out_valid_next = in_fire;
                if (in_fire) begin
                    out_data_next = s_data;
                end
            end
        end else if (in_fire) begin
            skid_valid_next = 1'b1;
            skid_data_next  = s_data;
        end
        ready_next = !skid_valid_next;
    end

    // State registers; ready stays low during reset and rises one cycle after
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_reg      <= 1'b0;
            out_valid_reg  <= 1'b0;
            skid_valid_reg <= 1'b0;
            out_data_reg   <= '0;
            skid_data_reg  <= '0;
        end else begin
            ready_reg      <= ready_next;
            out_valid_reg  <= out_valid_next;
            skid_valid_reg <= skid_valid_next;
            out_data_reg   <= out_data_next;
            skid_data_reg  <= skid_data_next;
        end
    end

    assign s_ready = ready_reg;
    assign m_valid = out_valid_reg;
    assign m_data  = out_data_reg;

endmodule

// File: rtl/axis_packet_framer.sv
// Packet framer behind the AXI-stream fan-in: prepends a header beat
// (magic, per-channel sequence number, channel), truncates payloads longer
// than MAX_WORDS beats and drops the overflow, and registers the output
// through a two-entry skid buffer.
module axis_packet_framer
    import axis_framer_pkg::*;
#(
    parameter int          NUM_CHAN   = 6,
    parameter int          DATA_WIDTH = 256,
    parameter int          SEQ_WIDTH  = 16,
    parameter int          MAX_WORDS  = 1024,
    parameter logic [15:0] HDR_MAGIC  = HDR_MAGIC_DEFAULT
) (
    input  logic                  s_axis_clk,
    input  logic                  s_axis_rstn,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tlast,
    input  logic [NUM_CHAN-1:0]   s_axis_tuser,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    output logic [USER_W-1:0]     m_axis_tuser,
    output logic                  err_chan,
    output logic [15:0]           trunc_count
);

    localparam int CNT_W    = $clog2(MAX_WORDS);
    localparam int CHAN_LSB = chan_lsb(SEQ_WIDTH);
    localparam int SKID_W   = USER_W + 1 + DATA_WIDTH;
    localparam logic [NUM_CHAN:0]  NUM_CHAN_VAL = (NUM_CHAN + 1)'(NUM_CHAN);
    localparam logic [CNT_W-1:0]   LAST_CNT     = CNT_W'(MAX_WORDS - 1);

    logic [1:0]                    state_reg;
    logic [CNT_W-1:0]              cnt_reg;
    logic [15:0]                   trunc_count_reg;
    logic [NUM_CHAN*SEQ_WIDTH-1:0] seq_flat;

    logic                  c_valid;
    logic                  c_ready;
    logic                  c_last;
    logic [USER_W-1:0]     c_user;
    logic [DATA_WIDTH-1:0] c_data;
    logic                  c_fire;
    logic                  hdr_fire;
    logic                  at_max;

    logic                  chan_ok;
    logic [NUM_CHAN-1:0]   chan_hit;
    logic [SEQ_WIDTH-1:0]  seq_sel;
    logic [CHAN_W-1:0]     chan8;
    logic [DATA_WIDTH-1:0] hdr_data;
    logic [SKID_W-1:0]     skid_out;

    // Channel decode at packet start; out-of-range numbers match no counter
    assign chan_ok = {1'b0, s_axis_tuser} < NUM_CHAN_VAL;
    assign chan8   = CHAN_W'(s_axis_tuser);
    assign c_fire  = c_valid && c_ready;
    assign hdr_fire = c_fire && (state_reg == ST_IDLE);
    assign at_max  = (cnt_reg == LAST_CNT);

    // One sequence counter per channel, bumped when its header is handed off
    for (genvar gi = 0; gi < NUM_CHAN; gi++) begin : g_seq
        logic [SEQ_WIDTH-1:0] seq_cnt_reg;

        assign chan_hit[gi] = (s_axis_tuser == NUM_CHAN'(gi));
        assign seq_flat[gi*SEQ_WIDTH +: SEQ_WIDTH] = seq_cnt_reg;

        // Per-channel counter, wraps naturally at 2^SEQ_WIDTH
        always_ff @(posedge s_axis_clk or negedge s_axis_rstn) begin
            if (!s_axis_rstn) begin
                seq_cnt_reg <= '0;
            end else if (hdr_fire && chan_hit[gi]) begin
                seq_cnt_reg <= seq_cnt_reg + 1'b1;
            end
        end
    end

    // Sequence value for the header; all ones flags an unknown channel
    always_comb begin
        seq_sel = '1;
        for (int i = 0; i < NUM_CHAN; i++) begin
            if (chan_hit[i]) begin
                seq_sel = seq_flat[i*SEQ_WIDTH +: SEQ_WIDTH];
            end
        end
    end

    // Header beat assembly; unused upper bits are zero
    always_comb begin
        hdr_data = '0;
        hdr_data[MAGIC_LSB +: MAGIC_W]  = HDR_MAGIC;
        hdr_data[SEQ_LSB +: SEQ_WIDTH]  = seq_sel;
        hdr_data[CHAN_LSB +: CHAN_W]    = chan8;
    end

    // Core output and upstream ready, selected by FSM state
    always_comb begin
        c_valid       = 1'b0;
        c_data        = s_axis_tdata;
        c_last        = 1'b0;
        c_user        = '0;
        s_axis_tready = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                // Header is emitted without consuming the first payload beat
                c_valid         = s_axis_tvalid;
                c_data          = hdr_data;
                c_user[HDR_BIT] = 1'b1;
            end
            ST_PAYLOAD: begin
                s_axis_tready     = c_ready;
                c_valid           = s_axis_tvalid;
                c_last            = s_axis_tlast || at_max;
                c_user[TRUNC_BIT] = at_max && !s_axis_tlast;
            end
            ST_DRAIN: begin
                s_axis_tready = 1'b1;
            end
            default: begin
                s_axis_tready = 1'b0;
            end
        endcase
    end

    // Framer FSM, payload word count and saturating truncation counter
    always_ff @(posedge s_axis_clk or negedge s_axis_rstn) begin
        if (!s_axis_rstn) begin
            state_reg       <= ST_IDLE;
            cnt_reg         <= '0;
            trunc_count_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (hdr_fire) begin
                        cnt_reg   <= '0;
                        state_reg <= ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    if (c_fire) begin
                        if (s_axis_tlast) begin
                            state_reg <= ST_IDLE;
                        end else if (at_max) begin
                            state_reg <= ST_DRAIN;
                            if (trunc_count_reg != 16'hFFFF) begin
                                trunc_count_reg <= trunc_count_reg + 16'd1;
                            end
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (s_axis_tvalid && s_axis_tlast) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign err_chan    = hdr_fire && !chan_ok;
    assign trunc_count = trunc_count_reg;

    axis_skid_buffer #(
        .WIDTH(SKID_W)
    ) u_skid (
        .clk     (s_axis_clk),
        .rst_n   (s_axis_rstn),
        .s_valid (c_valid),
        .s_ready (c_ready),
        .s_data  ({c_user, c_last, c_data}),
        .m_valid (m_axis_tvalid),
        .m_ready (m_axis_tready),
        .m_data  (skid_out)
    );

    assign m_axis_tdata = skid_out[DATA_WIDTH-1:0];
    assign m_axis_tlast = skid_out[DATA_WIDTH];
    assign m_axis_tuser = skid_out[SKID_W-1 -: USER_W];

endmodule

// File: tb/tb_axis_packet_framer.sv
// Directed and scoreboard bench for axis_packet_framer with a small
// configuration (6 channels, 64-bit data, 2-bit sequence, 4-beat limit).
module tb_axis_packet_framer;

    localparam int NC = 6;
    localparam int DW = 64;
    localparam int SW = 2;
    localparam int MW = 4;

    typedef logic [DW+2:0] beat_t;  // {user, last, data}
    typedef struct {
        int chan;
        int len;
        int seq;
        int nout;
    } vec_t;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data = '0;
    logic          s_last = 1'b0;
    logic [NC-1:0] s_user = '0;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic [1:0]    m_user;
    logic          err_chan;
    logic [15:0]   trunc_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int err_pulses = 0;
    int rand_ready = 0;

    beat_t got_q[$];
    int    got_cyc_q[$];
    beat_t exp_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    axis_packet_framer #(
        .NUM_CHAN   (NC),
        .DATA_WIDTH (DW),
        .SEQ_WIDTH  (SW),
        .MAX_WORDS  (MW),
        .HDR_MAGIC  (16'hA55A)
    ) dut (
        .s_axis_clk    (clk),
        .s_axis_rstn   (rstn),
        .s_axis_tvalid (s_valid),
        .s_axis_tready (s_ready),
        .s_axis_tdata  (s_data),
        .s_axis_tlast  (s_last),
        .s_axis_tuser  (s_user),
        .m_axis_tvalid (m_valid),
        .m_axis_tready (m_ready),
        .m_axis_tdata  (m_data),
        .m_axis_tlast  (m_last),
        .m_axis_tuser  (m_user),
        .err_chan      (err_chan),
        .trunc_count   (trunc_count)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] pdata(input int k, input int b);
        return 64'hC0DE_0000_0000_0000 | (64'(k) << 16) | 64'(b);
    endfunction

    // Output monitor: collects transfers, checks stall stability, counts err pulses
    initial begin
        logic  stall_prev;
        beat_t stall_beat;
        beat_t cur;
        stall_prev = 1'b0;
        stall_beat = '0;
        forever begin
            @(negedge clk);
            cur = {m_user, m_last, m_data};
            if (!rstn) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev)
                    chk("hold_stable", {m_valid, cur}, {1'b1, stall_beat});
                if (m_valid && m_ready) begin
                    got_q.push_back(cur);
                    got_cyc_q.push_back(cyc);
                end
                stall_prev = m_valid && !m_ready;
                stall_beat = cur;
                if (err_chan) err_pulses++;
            end
        end
    end

    // Downstream ready: constant 1 or random 50%
    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_ready = (rand_ready != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Global guard
    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    // Present one upstream beat and hold it until accepted (bounded)
    task automatic send_beat(input logic [DW-1:0] d, input logic l, input logic [NC-1:0] u);
        logic rdy;
        bit ok;
        ok = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        s_user  = u;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            rdy = s_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                ok = 1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL beat_accept: got no tready expected tready within 300 cycles");
        end
    endtask

    task automatic send_packet(input int k, input int chan, input int len);
        for (int b = 0; b < len; b++)
            send_beat(pdata(k, b), (b == len - 1), NC'(chan));
    endtask

    task automatic expect_pkt(input int k, input int chan, input int len, input int seq, input int nout);
        logic [DW-1:0] hdr;
        logic [1:0]    u;
        int            npay;
        hdr = 64'(16'hA55A) | (64'(seq & 3) << 16) | (64'(chan & 255) << 18);
        exp_q.push_back({2'b01, 1'b0, hdr});
        npay = nout - 1;
        for (int b = 0; b < npay; b++) begin
            u = ((b == npay - 1) && (npay < len)) ? 2'b10 : 2'b00;
            exp_q.push_back({u, (b == npay - 1), pdata(k, b)});
        end
    endtask

    // Wait for all expected beats (bounded), then compare in order
    task automatic compare_all(input string name);
        int waited;
        waited = 0;
        while (got_q.size() < exp_q.size() && waited < 5000) begin
            @(posedge clk);
            waited++;
        end
        repeat (4) @(posedge clk);
        chk({name, "_count"}, 128'(got_q.size()), 128'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s_beat%0d", name, i), 128'(got_q[i]), 128'(exp_q[i]));
        got_q.delete();
        got_cyc_q.delete();
        exp_q.delete();
    endtask

    initial begin
        vec_t tbl[13];
        int   seq_mdl[NC];
        int   trunc_mdl;
        int   start_cyc;
        int   chan;
        int   len;
        int   nout;

        // {chan, len, expected seq, expected output beats}
        tbl[0]  = '{2, 3, 0, 4};
        tbl[1]  = '{1, 1, 0, 2};
        tbl[2]  = '{1, 2, 1, 3};
        tbl[3]  = '{4, 4, 0, 5};   // exactly MAX_WORDS beats, not truncated
        tbl[4]  = '{1, 3, 2, 4};
        tbl[5]  = '{1, 1, 3, 2};
        tbl[6]  = '{1, 2, 0, 3};   // fifth chan-1 packet, sequence wraps
        tbl[7]  = '{3, 7, 0, 5};   // truncated, 3 beats dropped
        tbl[8]  = '{3, 2, 1, 3};
        tbl[9]  = '{7, 2, 3, 3};   // bad channel, seq all ones
        tbl[10] = '{2, 5, 1, 5};   // truncated, 1 beat dropped
        tbl[11] = '{5, 4, 0, 5};
        tbl[12] = '{0, 1, 0, 2};

        // Reset state
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_m_tvalid", 128'(m_valid), 128'(0));
        chk("rst_s_tready", 128'(s_ready), 128'(0));
        chk("rst_m_beat", 128'({m_user, m_last, m_data}), 128'(0));
        chk("rst_trunc_count", 128'(trunc_count), 128'(0));
        chk("rst_err_chan", 128'(err_chan), 128'(0));
        rstn = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Directed table, back-to-back packets, downstream always ready
        for (int k = 0; k < 13; k++) begin
            expect_pkt(k, tbl[k].chan, tbl[k].len, tbl[k].seq, tbl[k].nout);
            start_cyc = cyc;
            send_packet(k, tbl[k].chan, tbl[k].len);
            if (k == 0) begin
                if (got_cyc_q.size() > 0)
                    chk("hdr_latency", 128'(got_cyc_q[0] - start_cyc), 128'(1));
                else
                    chk("hdr_latency_seen", 128'(0), 128'(1));
            end
            $display("dir pkt %0d chan %0d len %0d exp_seq %0d", k, tbl[k].chan, tbl[k].len, tbl[k].seq);
        end
        s_valid = 1'b0;
        compare_all("dir");
        chk("dir_trunc_count", 128'(trunc_count), 128'(2));
        chk("dir_err_pulses", 128'(err_pulses), 128'(1));

        // Random packets against a stalling sink
        seq_mdl = '{1, 1, 2, 2, 1, 1};
        trunc_mdl = 0;
        rand_ready = 1;
        for (int k = 100; k < 200; k++) begin
            chan = $urandom_range(0, NC - 1);
            len  = $urandom_range(1, 6);
            nout = 1 + ((len > MW) ? MW : len);
            if (len > MW) trunc_mdl++;
            expect_pkt(k, chan, len, seq_mdl[chan], nout);
            seq_mdl[chan] = (seq_mdl[chan] + 1) % 4;
            send_packet(k, chan, len);
            $display("rnd pkt %0d chan %0d len %0d", k, chan, len);
            if ($urandom_range(0, 3) == 0) begin
                s_valid = 1'b0;
                repeat (2) @(posedge clk);
                #1;
            end
        end
        s_valid = 1'b0;
        compare_all("rnd");
        rand_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rnd_trunc_count", 128'(trunc_count), 128'(2 + trunc_mdl));
        chk("rnd_err_pulses", 128'(err_pulses), 128'(1));

        // Reset in the middle of a chan-1 payload
        send_beat(pdata(300, 0), 1'b0, NC'(1));
        send_beat(pdata(300, 1), 1'b0, NC'(1));
        #2;
        rstn = 1'b0;
        #1;
        chk("midrst_m_tvalid", 128'(m_valid), 128'(0));
        chk("midrst_trunc_count", 128'(trunc_count), 128'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        got_q.delete();
        got_cyc_q.delete();
        exp_q.delete();
        @(posedge clk);
        #1;
        expect_pkt(300, 1, 3, 0, 1);
        exp_q.push_back({2'b00, 1'b1, pdata(300, 2)});
        send_beat(pdata(300, 2), 1'b1, NC'(1));
        s_valid = 1'b0;
        $display("rst pkt 300 chan 1 remainder 1 beat");
        compare_all("midrst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
